// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. It compares two WIDTH-bit operands
//   CHUNK bits per cycle, starting with the most significant chunk, and stops
//   at the first chunk that differs. The lt/eq/gt cascade convention lets the
//   result chain with combinational comparators: the cascade inputs decide the
//   result only when every chunk is equal.
//
//   Optional build macro: SEQ_CMP_SIGNED_EN
//     defined   -> operands are two's complement. Differing sign bits decide
//                  the result in the first compare cycle.
//     undefined -> unsigned compare only. No sign logic is built.
//
//   Ports
//     clk            rising-edge clock
//     rst_n          synchronous active-low reset
//     start          request; accepted only while busy=0
//     a, b           WIDTH-bit operands, sampled on the accept edge
//     lt_in/eq_in/gt_in  cascade inputs, sampled on the accept edge
//     busy           comparison in progress
//     done           one-cycle pulse, result valid
//     lt_out/eq_out/gt_out  registered result, held until next result
//     chunks         number of chunks examined for the last result
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             lt_out,
    output logic             eq_out,
    output logic             gt_out,
    output logic [CNT_W-1:0] chunks
);

    localparam int unsigned NCH = WIDTH / CHUNK;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         casc_q, casc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic [CNT_W-1:0]   chunks_q, chunks_d;

    // Operands are shifted left after each compare, so the chunk under test
    // is always the top CHUNK bits of the captured registers.
    logic [CHUNK-1:0]   chunk_a_c;
    logic [CHUNK-1:0]   chunk_b_c;
    logic               last_c;
    logic               sign_dec_c;
    logic               sign_lt_c;

    assign chunk_a_c = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b_c = b_q[WIDTH-1 -: CHUNK];
    assign last_c    = (cnt_q == CNT_W'(NCH - 1));

`ifdef SEQ_CMP_SIGNED_EN
    // Only the first compare cycle still holds the original sign bits.
    assign sign_dec_c = (cnt_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
    assign sign_lt_c  = a_q[WIDTH-1];
`else
    assign sign_dec_c = 1'b0;
    assign sign_lt_c  = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            chunks_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            casc_q   <= casc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            chunks_q <= chunks_d;
        end
    end

    // Next-state and result logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        casc_d   = casc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        chunks_d = chunks_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    casc_d  = {lt_in, eq_in, gt_in};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end

            CMP: begin
                cnt_d = cnt_q + CNT_W'(1);
                a_d   = a_q << CHUNK;
                b_d   = b_q << CHUNK;
                if (sign_dec_c) begin
                    lt_d     = sign_lt_c;
                    eq_d     = 1'b0;
                    gt_d     = ~sign_lt_c;
                    chunks_d = CNT_W'(1);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (chunk_a_c != chunk_b_c) begin
                    lt_d     = (chunk_a_c < chunk_b_c);
                    eq_d     = 1'b0;
                    gt_d     = (chunk_a_c > chunk_b_c);
                    chunks_d = cnt_q + CNT_W'(1);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (last_c) begin
                    // All chunks equal: cascade inputs pass through verbatim.
                    lt_d     = casc_q[2];
                    eq_d     = casc_q[1];
                    gt_d     = casc_q[0];
                    chunks_d = CNT_W'(NCH);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign lt_out = lt_q;
    assign eq_out = eq_q;
    assign gt_out = gt_q;
    assign chunks = chunks_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
// The reference model works on whole operand values: the result is a plain
// magnitude compare (or the cascade inputs when equal), and the chunk count is
// the position of the most significant differing chunk.
module tb_seq_magnitude_comparator;

    localparam int unsigned W     = 16;
    localparam int unsigned C     = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned NCH   = W / C;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             lt_in, eq_in, gt_in;
    logic             busy, done;
    logic             lt_out, eq_out, gt_out;
    logic [CNT_W-1:0] chunks;

    int checks = 0;
    int errors = 0;
    logic [2:0] prev_res;
    int         prev_k;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .lt_in  (lt_in),
        .eq_in  (eq_in),
        .gt_in  (gt_in),
        .busy   (busy),
        .done   (done),
        .lt_out (lt_out),
        .eq_out (eq_out),
        .gt_out (gt_out),
        .chunks (chunks)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result {lt,eq,gt} and number of chunks examined.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] casc, output logic [2:0] res, output int k);
        bit found;
        bit is_lt;
        found = 1'b0;
        k     = NCH;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!found && ((av >> (i * C)) != (bv >> (i * C)))) begin
                found = 1'b1;
                k     = NCH - i;
            end
        end
`ifdef SEQ_CMP_SIGNED_EN
        is_lt = ($signed(av) < $signed(bv));
`else
        is_lt = (av < bv);
`endif
        if (av == bv) res = casc;
        else          res = {is_lt, 1'b0, ~is_lt};
    endtask

    function automatic logic [31:0] res_now();
        return {29'd0, lt_out, eq_out, gt_out};
    endfunction

    // One comparison from an idle negedge; returns at the negedge after done.
    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] casc);
        logic [2:0] er;
        int ek;
        int cyc;
        model(av, bv, casc, er, ek);
        a = av;
        b = bv;
        {lt_in, eq_in, gt_in} = casc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc <= int'(NCH) + 2) begin
            chk("busy_during", 32'(busy), 32'd1);
            chk("held_result", res_now(), 32'(prev_res));
            chk("held_chunks", 32'(chunks), 32'(prev_k));
            // Disturb inputs while busy; none of it may be taken.
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            {lt_in, eq_in, gt_in} = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'(ek));
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("result", res_now(), 32'(er));
        chk("chunks", 32'(chunks), 32'(ek));
        prev_res = er;
        prev_k   = ek;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("result_held", res_now(), 32'(prev_res));
    endtask

    initial begin
        logic [2:0] er;
        int ek;
        int cyc;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        {lt_in, eq_in, gt_in} = 3'b000;
        prev_res = 3'b000;
        prev_k   = 0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", res_now(), 32'd0);
        chk("rst_chunks", 32'(chunks), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_cmp(16'h8000, 16'h7FFF, 3'b000);
        do_cmp(16'h1234, 16'h1235, 3'b000);
        do_cmp(16'hABCD, 16'hABCD, 3'b010);
        do_cmp(16'hABCD, 16'hABCD, 3'b100);
        do_cmp(16'h5555, 16'h5555, 3'b111);
        do_cmp(16'h0000, 16'hFFFF, 3'b010);

        // Start held high: a new request is taken in the cycle done is high
        model(16'h0100, 16'h0200, 3'b000, er, ek);
        a = 16'h0100;
        b = 16'h0200;
        {lt_in, eq_in, gt_in} = 3'b000;
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (busy === 1'b1 && done !== 1'b1) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
            end while (done !== 1'b1 && cyc < 12);
            a = 16'h0100;
            b = 16'h0200;
            if (r == 2) start = 1'b0;
            chk("hs_interval", 32'(cyc), 32'(ek + 1));
            chk("hs_done", 32'(done), 32'd1);
            chk("hs_result", res_now(), 32'(er));
            chk("hs_chunks", 32'(chunks), 32'(ek));
        end
        prev_res = er;
        prev_k   = ek;
        @(negedge clk);
        chk("hs_stop_busy", 32'(busy), 32'd0);
        chk("hs_stop_done", 32'(done), 32'd0);

        // Reset mid-comparison
        a = 16'h0001;
        b = 16'h0001;
        {lt_in, eq_in, gt_in} = 3'b010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("mid_busy2", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", res_now(), 32'd0);
        chk("mid_rst_chunks", 32'(chunks), 32'd0);
        @(negedge clk);
        chk("mid_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        prev_res = 3'b000;
        prev_k   = 0;
        @(negedge clk);
        chk("mid_after_done", 32'(done), 32'd0);
        do_cmp(16'h0001, 16'h0001, 3'b010);

        // Randomized
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            do_cmp(ra, rb, 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
